// File: rtl/ssd_scan_n_if.sv
// ssd_scan_n_if: user-side bus of the multiplexed seven-segment scanner.
//   master : user logic; drives digits/dp/enable/blink/load/brightness and
//            observes the pin-level outputs seg/dp_n/an/frame.
//   slave  : the scanner itself.
// load is a single-cycle strobe with no ready: the scanner accepts it on any
// cycle it is high, and the captured values become visible at the next frame
// boundary (or at once when load coincides with the boundary cycle).
interface ssd_scan_n_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   enable;
  logic [DIGITS-1:0]   blink;
  logic                load;
  logic [3:0]          brightness;
  logic [6:0]          seg;
  logic                dp_n;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output digits, dp, enable, blink, load, brightness,
    input  seg, dp_n, an, frame
  );

  modport slave (
    input  digits, dp, enable, blink, load, brightness,
    output seg, dp_n, an, frame
  );
endinterface

// File: rtl/ssd_scan_n.sv
// ssd_scan_n: multiplexed seven-segment controller for DIGITS common-anode
// digits with per-digit dp/enable/blink, 4-bit PWM brightness, inter-digit
// blanking and double-buffered (shadow -> active) loading.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low
//   bus  ssd_scan_n_if.slave: digits/dp/enable/blink/load/brightness in,
//        seg/dp_n/an (all active-low) and frame pulse out
module ssd_scan_n #(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 65536,
  parameter int BLANK        = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  ssd_scan_n_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [3:0]    pwm;
  logic [FW-1:0] fcnt;
  logic          blink_ph;

  logic [4*DIGITS-1:0] digit_s, digit_a;
  logic [DIGITS-1:0]   dp_s, dp_a;
  logic [DIGITS-1:0]   en_s, en_a;
  logic [DIGITS-1:0]   bl_s, bl_a;

  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_q;

  logic       slot_end, frame_end;
  logic       dark, lit;
  logic [3:0] nib;
  logic [6:0] hex_seg;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_comb begin
    dark    = 1'b0;
    lit     = 1'b0;
    nib     = 4'h0;
    hex_seg = 7'h7F;
    an_d    = '1;
    seg_d   = 7'h7F;
    dp_n_d  = 1'b1;

    dark = ~en_a[idx] | (bl_a[idx] & blink_ph);
    // The first BLANK cycles of every slot stay dark so the previous digit's
    // segment pattern cannot ghost onto the newly selected anode.
    lit  = ~dark & (cnt >= CNT_BLANK) & (pwm <= bus.brightness);
    nib  = digit_a[{idx, 2'b00} +: 4];

    case (nib)
      4'h0: hex_seg = 7'b0000001;
      4'h1: hex_seg = 7'b1001111;
      4'h2: hex_seg = 7'b0010010;
      4'h3: hex_seg = 7'b0000110;
      4'h4: hex_seg = 7'b1001100;
      4'h5: hex_seg = 7'b0100100;
      4'h6: hex_seg = 7'b0100000;
      4'h7: hex_seg = 7'b0001111;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0000100;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b1100000;
      4'hC: hex_seg = 7'b0110001;
      4'hD: hex_seg = 7'b1000010;
      4'hE: hex_seg = 7'b0110000;
      default: hex_seg = 7'b0111000;
    endcase

    if (lit) begin
      an_d  = ~(DIGITS'(1) << idx);
      seg_d = hex_seg;
    end
    dp_n_d = ~(lit & dp_a[idx]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      idx      <= '0;
      pwm      <= '0;
      fcnt     <= '0;
      blink_ph <= 1'b0;
      digit_s  <= '0;
      dp_s     <= '0;
      en_s     <= '0;
      bl_s     <= '0;
      digit_a  <= '0;
      dp_a     <= '0;
      en_a     <= '0;
      bl_a     <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_n_q   <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      pwm <= pwm + 1'b1;

      if (bus.load) begin
        digit_s <= bus.digits;
        dp_s    <= bus.dp;
        en_s    <= bus.enable;
        bl_s    <= bus.blink;
      end

      // Active copy only changes between frames, so a frame never mixes old
      // and new values. A load on the boundary cycle itself would otherwise
      // miss this transfer and wait a whole extra frame, hence the bypass.
      if (frame_end) begin
        digit_a <= bus.load ? bus.digits : digit_s;
        dp_a    <= bus.load ? bus.dp     : dp_s;
        en_a    <= bus.load ? bus.enable : en_s;
        bl_a    <= bus.load ? bus.blink  : bl_s;
        if (fcnt == FR_LAST) begin
          fcnt     <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
      frame_q <= frame_end;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp_n  = dp_n_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_ssd_scan_n.sv
module tb_ssd_scan_n;
  localparam int DIGITS       = 3;
  localparam int PRESCALE     = 20;
  localparam int BLANK        = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int W            = 22;  // {an, seg, lit count, dp count, frame count}

  logic clk = 1'b0;
  logic rst = 1'b0;

  ssd_scan_n_if #(.DIGITS(DIGITS)) bus ();

  ssd_scan_n #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset-relative cycle counter ----------------
  always #5 clk = ~clk;

  // t = index of the DUT state currently held (0 = first cycle after reset).
  int t = 0;
  always @(posedge clk) begin
    if (!rst) t <= 0;
    else      t <= t + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  checks = 0;
  int  fails  = 0;
  bit  mon_en = 1'b0;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h5: return 7'b0100100;
      4'h7: return 7'b0001111;
      4'hA: return 7'b0001000;
      4'hC: return 7'b0110001;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Expected summary of one slot window s (states 20s..20s+19, idx = s%3).
  // The frame pulse for each boundary lands in the last sample of idx-2 windows.
  function automatic logic [W-1:0] slot_rec(input int s, input logic [11:0] dig,
      input logic [2:0] en, input logic [2:0] bl, input logic [2:0] dpv, input int br);
    int i;
    int f;
    int lit;
    bit ph;
    bit dark;
    logic [2:0] an_e;
    logic [6:0] seg_e;
    logic [3:0] nib;
    i    = s % DIGITS;
    f    = s / DIGITS;
    ph   = ((f / BLINK_FRAMES) % 2) == 1;
    dark = !en[i] || (bl[i] && ph);
    lit  = 0;
    if (!dark)
      for (int tt = PRESCALE*s + BLANK; tt < PRESCALE*s + PRESCALE; tt++)
        if ((tt % 16) <= br) lit++;
    nib   = dig[4*i +: 4];
    an_e  = (lit > 0) ? ~(3'b001 << i) : 3'b111;
    seg_e = (lit > 0) ? hexseg(nib) : 7'h7F;
    return {an_e, seg_e, 5'(lit), 5'(dpv[i] ? lit : 0), 2'((i == DIGITS-1) ? 1 : 0)};
  endfunction

  task automatic push_frame(input int f, input logic [11:0] dig, input logic [2:0] en,
      input logic [2:0] bl, input logic [2:0] dpv, input int br);
    for (int i = 0; i < DIGITS; i++)
      exp_q.push_back(slot_rec(DIGITS*f + i, dig, en, bl, dpv, br));
  endtask

  // ---------------- monitor ----------------
  logic [2:0]   an_and;
  logic [6:0]   seg_and;
  int           lit_n, dp_cnt, fr_n, pos, slot;
  logic [W-1:0] got_rec, exp_rec;

  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      an_and  = '1;
      seg_and = '1;
      lit_n   = 0;
      dp_cnt  = 0;
      fr_n    = 0;
    end else if (t >= 1) begin
      pos  = (t - 1) % PRESCALE;
      slot = (t - 1) / PRESCALE;
      if (pos == 0) begin
        an_and  = '1;
        seg_and = '1;
        lit_n   = 0;
        dp_cnt  = 0;
        fr_n    = 0;
      end
      an_and  = an_and & bus.an;
      seg_and = seg_and & bus.seg;
      if (bus.an != 3'b111) lit_n++;
      if (!bus.dp_n)        dp_cnt++;
      if (bus.frame)        fr_n++;
      if (pos == PRESCALE - 1) begin
        got_rec = {an_and, seg_and, 5'(lit_n), 5'(dp_cnt), 2'(fr_n)};
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL slot_unexpected slot=%0d got=%h required=no window", slot, got_rec);
        end else begin
          exp_rec = exp_q.pop_front();
          if (got_rec !== exp_rec) begin
            fails++;
            $display("FAIL slot_window slot=%0d got an=%b seg=%b lit=%0d dp=%0d fr=%0d required an=%b seg=%b lit=%0d dp=%0d fr=%0d",
              slot, got_rec[21:19], got_rec[18:12], got_rec[11:7], got_rec[6:2], got_rec[1:0],
              exp_rec[21:19], exp_rec[18:12], exp_rec[11:7], exp_rec[6:2], exp_rec[1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic wait_t(input int n);
    int budget;
    budget = 0;
    while (t != n && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (t != n) begin
      fails++;
      $display("FAIL wait_timeout got=%0d required=%0d", t, n);
    end
  endtask

  task automatic do_load(input int n, input logic [11:0] dig, input logic [2:0] en,
      input logic [2:0] bl, input logic [2:0] dpv);
    wait_t(n);
    bus.digits = dig;
    bus.enable = en;
    bus.blink  = bl;
    bus.dp     = dpv;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("reset_an",    32'(bus.an),    32'h7);
    check("reset_seg",   32'(bus.seg),   32'h7F);
    check("reset_dp_n",  32'(bus.dp_n),  32'h1);
    check("reset_frame", 32'(bus.frame), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.digits     = '0;
    bus.dp         = '0;
    bus.enable     = '0;
    bus.blink      = '0;
    bus.load       = 1'b0;
    bus.brightness = 4'd15;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    rst    = 1'b1;
    mon_en = 1'b1;

    // Frame 0 dark (active copy still zero), frame 1 shows 5A3.
    push_frame(0, 12'h000, 3'b000, 3'b000, 3'b000, 15);
    push_frame(1, 12'h5A3, 3'b111, 3'b000, 3'b000, 15);
    do_load(5, 12'h5A3, 3'b111, 3'b000, 3'b000);

    // Mid-frame load: frame 2 keeps 5A3, frame 3 shows 000.
    push_frame(2, 12'h5A3, 3'b111, 3'b000, 3'b000, 15);
    push_frame(3, 12'h000, 3'b111, 3'b000, 3'b000, 15);
    do_load(130, 12'h000, 3'b111, 3'b000, 3'b000);

    // Load on the boundary cycle (state 239) takes effect in frame 4;
    // then brightness 0 for frame 5, 7 for frame 6, 15 again for frame 7.
    push_frame(4, 12'h777, 3'b111, 3'b000, 3'b000, 15);
    push_frame(5, 12'h777, 3'b111, 3'b000, 3'b000, 0);
    push_frame(6, 12'h777, 3'b111, 3'b000, 3'b000, 7);
    push_frame(7, 12'h777, 3'b111, 3'b000, 3'b000, 15);
    do_load(239, 12'h777, 3'b111, 3'b000, 3'b000);
    wait_t(300);
    bus.brightness = 4'd0;
    wait_t(360);
    bus.brightness = 4'd7;
    wait_t(420);
    bus.brightness = 4'd15;

    // Blink digit 1 and dp on digit 0, active from frame 8.
    for (int f = 8; f < 14; f++)
      push_frame(f, 12'h2C1, 3'b111, 3'b010, 3'b001, 15);
    do_load(430, 12'h2C1, 3'b111, 3'b010, 3'b001);

    // Mid-slot reset while digit 0 is lit with its dp on.
    wait_t(845);
    mon_en = 1'b0;
    check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst    = 1'b1;
    mon_en = 1'b1;

    // No new load: cleared shadow keeps both following frames dark.
    push_frame(0, 12'h000, 3'b000, 3'b000, 3'b000, 15);
    push_frame(1, 12'h000, 3'b000, 3'b000, 3'b000, 15);
    wait_t(121);
    check("queue_drained_at_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
